fp_normalizer: RTL and testbench



---
 rtl/fp_normalizer.sv | 132 +++++++++++++
 tb/tb_fp_normalizer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// Post-add normalizer for binary32: carry right-shift or left-shift to hidden bit.
// Define FP_NORM_FAST_LZC_EN for a single-cycle LZC shift instead of 1-bit steps.
module fp_normalizer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exp,
  output logic [22:0] out_mant,
  output logic        out_zero,
  output logic        out_underflow,
  output logic        out_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t      state;
  logic        sign;
  logic [8:0]  exp;
  logic [24:0] mant;
  logic [8:0]  exp_inc;
  logic [8:0]  shamt;
  logic        term;

  assign in_ready = rstn && (state == IDLE);
  assign exp_inc  = exp + 9'd1;

  assign term = (mant == 25'd0) || (exp == 9'd255) ||
                mant[24] || mant[23] || (exp == 9'd1);

`ifdef FP_NORM_FAST_LZC_EN
  logic [4:0] lzc;

  always_comb begin
    lzc = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (mant[i]) lzc = 5'(23 - i);
    end
  end

  // Never shift past exp=1; the next step then clamps to denormal.
  always_comb begin
    shamt = {4'd0, lzc};
    if ({4'd0, lzc} > exp - 9'd1) shamt = exp - 9'd1;
  end
`else
  assign shamt = 9'd1;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      sign          <= 1'b0;
      exp           <= 9'd0;
      mant          <= 25'd0;
      out_valid     <= 1'b0;
      out_sign      <= 1'b0;
      out_exp       <= 8'd0;
      out_mant      <= 23'd0;
      out_zero      <= 1'b0;
      out_underflow <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign          <= in_sign;
            exp           <= (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};
            mant          <= in_mant;
            out_zero      <= 1'b0;
            out_underflow <= 1'b0;
            out_overflow  <= 1'b0;
            state         <= NORM;
          end
        end
        NORM: begin
          if (term) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_sign  <= sign;
          end
          if (mant == 25'd0) begin
            out_exp  <= 8'd0;
            out_mant <= 23'd0;
            out_zero <= 1'b1;
          end else if (exp == 9'd255) begin
            out_exp      <= 8'hff;
            out_mant     <= 23'd0;
            out_overflow <= 1'b1;
          end else if (mant[24]) begin
            if (exp_inc == 9'd255) begin
              out_exp      <= 8'hff;
              out_mant     <= 23'd0;
              out_overflow <= 1'b1;
            end else begin
              out_exp  <= exp_inc[7:0];
              out_mant <= mant[23:1];
            end
          end else if (mant[23]) begin
            out_exp  <= exp[7:0];
            out_mant <= mant[22:0];
          end else if (exp == 9'd1) begin
            out_exp       <= 8'd0;
            out_mant      <= mant[22:0];
            out_underflow <= 1'b1;
          end else begin
            mant <= mant << shamt;
            exp  <= exp - shamt;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed cases plus random results
// checked against an arithmetic reference model.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_mant;
  logic        out_zero;
  logic        out_underflow;
  logic        out_overflow;

  int vectors = 0;
  int miscompares = 0;

  fp_normalizer dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sign      (out_sign),
    .out_exp       (out_exp),
    .out_mant      (out_mant),
    .out_zero      (out_zero),
    .out_underflow (out_underflow),
    .out_overflow  (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Value-level reference: find how far the MSB is from bit 23 and
  // limit the left shift so the exponent never goes below 1.
  task automatic model(input logic [7:0] ie, input logic [24:0] m,
                       output logic [7:0] oe, output logic [22:0] om,
                       output logic [2:0] fl, output int lat);
    int e;
    int k;
    int s;
    longint v;
    e  = (ie == 0) ? 1 : int'(ie);
    s  = 0;
    fl = 3'b000;
    oe = 8'd0;
    om = 23'd0;
    v  = longint'(m);
    if (v == 0) begin
      fl = 3'b100;
    end else if (e == 255) begin
      fl = 3'b001;
      oe = 8'd255;
    end else if (v >= 64'd16777216) begin
      if (e + 1 == 255) begin
        fl = 3'b001;
        oe = 8'd255;
      end else begin
        oe = 8'(e + 1);
        om = 23'((v / 2) % 8388608);
      end
    end else begin
      k = 0;
      while ((v << k) < 64'd8388608) k++;
      if (k <= e - 1) begin
        s  = k;
        oe = 8'(e - k);
      end else begin
        s  = e - 1;
        oe = 8'd0;
        fl = 3'b010;
      end
      om = 23'((v << s) % 8388608);
    end
`ifdef FP_NORM_FAST_LZC_EN
    lat = (s > 0) ? 2 : 1;
`else
    lat = 1 + s;
`endif
  endtask

  task automatic xact(input logic s, input logic [7:0] e,
                      input logic [24:0] m, input int hold);
    logic [7:0]  oe;
    logic [22:0] om;
    logic [2:0]  fl;
    int          lat;
    int          n;
    logic [34:0] snap;
    model(e, m, oe, om, fl, lat);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    chk("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, lat);
    chk("out_sign", out_sign, s);
    chk("out_exp", out_exp, oe);
    chk("out_mant", out_mant, om);
    chk("flags", {out_zero, out_underflow, out_overflow}, fl);
    snap = {out_sign, out_exp, out_mant, out_zero, out_underflow, out_overflow};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_data", {out_sign, out_exp, out_mant, out_zero,
                        out_underflow, out_overflow}, snap);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("released", out_valid, 1'b0);
    chk("ready_after", in_ready, 1'b1);
  endtask

  initial begin
    logic [7:0]  e;
    logic [24:0] m;
    int          bits;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 25'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_data", {out_sign, out_exp, out_mant, out_zero,
                     out_underflow, out_overflow}, 35'd0);
    rstn = 1'b1;
    #1;
    chk("ready_on_release", in_ready, 1'b1);

    xact(1'b0, 8'd130, 25'h0C00000, 0);
    xact(1'b0, 8'd130, 25'h1800000, 0);
    xact(1'b1, 8'd254, 25'h1800000, 1);
    xact(1'b0, 8'd127, 25'h0000001, 0);
    xact(1'b0, 8'd3, 25'h0100000, 0);
    xact(1'b1, 8'd77, 25'h0000000, 5);
    xact(1'b0, 8'd255, 25'h0400000, 0);
    xact(1'b1, 8'd0, 25'h0012345, 0);
    xact(1'b0, 8'd1, 25'h0800000, 0);
    xact(1'b0, 8'd24, 25'h0000001, 0);

    // Reset in the middle of a long left-shift sequence.
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 8'd127;
    in_mant  = 25'h0000001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_data", {out_sign, out_exp, out_mant, out_zero,
                        out_underflow, out_overflow}, 35'd0);
    rstn = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      chk("midrst_discard", out_valid, 1'b0);
    end
    xact(1'b0, 8'd130, 25'h0C00000, 0);

    for (int t = 0; t < 200; t++) begin
      bits = $urandom_range(25, 0);
      m = 25'($urandom) & 25'((64'd1 << bits) - 1);
      case ($urandom_range(5, 0))
        0: e = 8'd0;
        1: e = 8'($urandom_range(4, 1));
        2: e = 8'($urandom_range(255, 250));
        default: e = 8'($urandom);
      endcase
      xact(1'($urandom), e, m, $urandom_range(2, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
